// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall generation for the EX stage.
// Resolves both sources against every write lane of the downstream stages and keeps saturating event counters.
module fwd_hazard_unit #(
  parameter int AW               = 5,
  parameter int ISSUE_W          = 2,
  parameter int NUM_STAGES       = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int ZERO_REG         = 1,
  parameter int CNT_W            = 16,
  parameter int SEL_W            = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             id_valid,
  input  logic                             flush,
  input  logic [AW-1:0]                    rs_1,
  input  logic [AW-1:0]                    rs_2,
  input  logic [NUM_STAGES*ISSUE_W*AW-1:0] stg_rd,
  input  logic [NUM_STAGES*ISSUE_W-1:0]    stg_rgw,
  input  logic [NUM_STAGES*ISSUE_W-1:0]    stg_ld,
  output logic [SEL_W-1:0]                 fa,
  output logic [SEL_W-1:0]                 fb,
  output logic                             stall,
  output logic [CNT_W-1:0]                 fwd_cnt,
  output logic [CNT_W-1:0]                 stall_cnt
);

  localparam int DW = $clog2(NUM_STAGES + 1);
  localparam logic [DW-1:0] LRS_D = DW'(LOAD_READY_STAGE);

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic             hit;
    logic             ld;
    logic [DW-1:0]    stg;
    logic [SEL_W-1:0] sel;
  } match_t;

  // Scan from lowest to highest priority so the last hit written is the winner.
  function automatic match_t lookup(input logic [AW-1:0] rs);
    match_t m;
    m = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      for (int l = 0; l < ISSUE_W; l++) begin
        if (stg_rgw[s*ISSUE_W + l] && (stg_rd[(s*ISSUE_W + l)*AW +: AW] == rs) &&
            !((ZERO_REG != 0) && (rs == '0))) begin
          m.hit = 1'b1;
          m.ld  = stg_ld[s*ISSUE_W + l];
          m.stg = DW'(s);
          m.sel = SEL_W'(1 + s*ISSUE_W + (ISSUE_W - 1 - l));
        end
      end
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  state_t          state_q, state_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  match_t          m_a, m_b;
  logic            haz_a, haz_b, hazard;
  logic [DW-1:0]   s_min, d;
  logic            stall_c;

  always_comb begin
    m_a   = lookup(rs_1);
    m_b   = lookup(rs_2);
    haz_a = m_a.hit && m_a.ld && (m_a.stg < LRS_D);
    haz_b = m_b.hit && m_b.ld && (m_b.stg < LRS_D);
    // The nearer load sets the wait length when both sources hazard.
    if (haz_a && haz_b) s_min = (m_a.stg < m_b.stg) ? m_a.stg : m_b.stg;
    else if (haz_a)     s_min = m_a.stg;
    else                s_min = m_b.stg;
    d      = LRS_D - s_min;
    hazard = id_valid && (state_q == RUN) && !flush && (haz_a || haz_b);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard) begin
          stall_c = 1'b1;
          if (d >= DW'(2)) begin
            state_d = STALL;
            cnt_d   = d - DW'(2);
          end
        end
      end
      STALL: begin
        stall_c = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (flush) begin
      stall_c = 1'b0;
      state_d = RUN;
      cnt_d   = '0;
    end
    // Reset must drop the stall without waiting for a clock edge.
    if (!rst_n) stall_c = 1'b0;
  end

  assign stall = stall_c;
  assign fa    = (stall_c || !rst_n) ? '0 : m_a.sel;
  assign fb    = (stall_c || !rst_n) ? '0 : m_b.sel;

  always_comb begin
    fwd_cnt_d   = sat_inc(fwd_cnt_q, id_valid && !stall_c && ((fa != '0) || (fb != '0)));
    stall_cnt_d = sat_inc(stall_cnt_q, stall_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt   = fwd_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: instance A (defaults, 4-bit counters) and
// instance B (ZERO_REG=0, LOAD_READY_STAGE=2) driven with directed vectors.
module tb_fwd_hazard_unit;

  localparam int AW = 5;
  localparam int NE = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_vld, a_flush, b_vld, b_flush;
  logic [AW-1:0] a_rs1, a_rs2, b_rs1, b_rs2;
  logic [NE*AW-1:0] a_rd, b_rd;
  logic [NE-1:0] a_rgw, a_ld, b_rgw, b_ld;
  logic [2:0]    a_fa, a_fb, b_fa, b_fb;
  logic          a_st, b_st;
  logic [3:0]    a_fw, a_sc;
  logic [15:0]   b_fw, b_sc;

  fwd_hazard_unit #(.CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(a_vld), .flush(a_flush),
    .rs_1(a_rs1), .rs_2(a_rs2), .stg_rd(a_rd), .stg_rgw(a_rgw), .stg_ld(a_ld),
    .fa(a_fa), .fb(a_fb), .stall(a_st), .fwd_cnt(a_fw), .stall_cnt(a_sc)
  );

  fwd_hazard_unit #(.ZERO_REG(0), .LOAD_READY_STAGE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(b_vld), .flush(b_flush),
    .rs_1(b_rs1), .rs_2(b_rs2), .stg_rd(b_rd), .stg_rgw(b_rgw), .stg_ld(b_ld),
    .fa(b_fa), .fb(b_fb), .stall(b_st), .fwd_cnt(b_fw), .stall_cnt(b_sc)
  );

  typedef struct {
    string nm;
    int    dut;
    int    fa, fb, st, fw, sc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    if (exp >= 0) begin
      n_tests++;
      if (act != exp) begin
        n_fail++;
        $display("FAIL %s %s: got %0d expected %0d", nm, fld, act, exp);
      end
    end
  endtask

  // Monitor: every cycle, retire whatever the driver queued for it.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.dut == 0) begin
        cmp(e.nm, "fa", int'(a_fa), e.fa);
        cmp(e.nm, "fb", int'(a_fb), e.fb);
        cmp(e.nm, "stall", int'(a_st), e.st);
        cmp(e.nm, "fwd_cnt", int'(a_fw), e.fw);
        cmp(e.nm, "stall_cnt", int'(a_sc), e.sc);
      end else begin
        cmp(e.nm, "fa", int'(b_fa), e.fa);
        cmp(e.nm, "fb", int'(b_fb), e.fb);
        cmp(e.nm, "stall", int'(b_st), e.st);
        cmp(e.nm, "fwd_cnt", int'(b_fw), e.fw);
        cmp(e.nm, "stall_cnt", int'(b_sc), e.sc);
      end
    end
  end

  task automatic expect_(input string nm, input int dut, input int fa, input int fb,
                         input int st, input int fw, input int sc);
    exp_t e;
    e.nm = nm; e.dut = dut; e.fa = fa; e.fb = fb; e.st = st; e.fw = fw; e.sc = sc;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int dut);
    if (dut == 0) begin
      a_vld = 0; a_flush = 0; a_rs1 = '0; a_rs2 = '0; a_rd = '0; a_rgw = '0; a_ld = '0;
    end else begin
      b_vld = 0; b_flush = 0; b_rs1 = '0; b_rs2 = '0; b_rd = '0; b_rgw = '0; b_ld = '0;
    end
  endtask

  task automatic put(input int dut, input int e, input int rd, input bit ld);
    if (dut == 0) begin
      a_rd[e*AW +: AW] = rd[AW-1:0]; a_rgw[e] = 1'b1; a_ld[e] = ld;
    end else begin
      b_rd[e*AW +: AW] = rd[AW-1:0]; b_rgw[e] = 1'b1; b_ld[e] = ld;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(0); idle(1);
    tick();

    // Inputs that would forward, held under reset
    a_vld = 1; a_rs1 = 7; put(0, 1, 7, 0);
    b_vld = 1; b_rs1 = 4; put(1, 0, 4, 1);
    expect_("reset_a", 0, 0, 0, 0, 0, 0);
    expect_("reset_b", 1, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1; idle(0); idle(1);

    // ---- instance A: LOAD_READY_STAGE=1, ZERO_REG=1, CNT_W=4 ----
    idle(0); a_vld = 1; a_rs1 = 7; put(0, 1, 7, 0); put(0, 2, 7, 0);
    expect_("a_s0l1_over_s1l0", 0, 1, 0, 0, 0, 0); tick();
    idle(0); a_vld = 1; a_rs2 = 9; put(0, 0, 9, 0); put(0, 3, 9, 0);
    expect_("a_s0l0_over_s1l1", 0, 0, 2, 0, 1, 0); tick();
    idle(0); a_vld = 1; a_rs2 = 9; a_rd[0 +: AW] = 5'd9; put(0, 3, 9, 0);
    expect_("a_s1l1_after_drop", 0, 0, 3, 0, 2, 0); tick();
    idle(0); a_vld = 1; a_rs2 = 9; put(0, 4, 9, 0);
    expect_("a_s2l0_only", 0, 0, 6, 0, 3, 0); tick();
    idle(0); a_vld = 1; put(0, 1, 0, 0);
    expect_("a_zero_reg", 0, 0, 0, 0, 4, 0); tick();
    idle(0); a_vld = 1; a_rs1 = 4; put(0, 0, 4, 1);
    expect_("a_loaduse_stall", 0, 0, 0, 1, 4, 0); tick();
    idle(0); a_vld = 1; a_rs1 = 4; put(0, 2, 4, 1);
    expect_("a_load_from_s1", 0, 4, 0, 0, 4, 1); tick();
    idle(0); a_vld = 1; a_rs1 = 5; put(0, 1, 5, 0); put(0, 0, 5, 1);
    expect_("a_nonload_lane_wins", 0, 1, 0, 0, 5, 1); tick();
    idle(0); a_vld = 1; a_rs2 = 6; put(0, 0, 6, 1); put(0, 2, 6, 0);
    expect_("a_young_load_unmasked", 0, 0, 0, 1, 6, 1); tick();
    idle(0); a_vld = 0; a_rs1 = 3; put(0, 0, 3, 1); put(0, 5, 3, 0);
    expect_("a_invalid_no_stall", 0, 2, 0, 0, 6, 2); tick();
    idle(0); a_vld = 1; a_flush = 1; a_rs1 = 3; put(0, 0, 3, 1);
    expect_("a_flush_blocks_stall", 0, 2, 0, 0, 6, 2); tick();
    for (int i = 0; i < 20; i++) begin
      idle(0); a_vld = 1; a_rs1 = 7; put(0, 1, 7, 0);
      expect_("a_fwd_saturate", 0, 1, 0, 0, (7 + i > 15) ? 15 : 7 + i, 2); tick();
    end
    idle(0);

    // ---- instance B: LOAD_READY_STAGE=2, ZERO_REG=0 ----
    idle(1); b_vld = 1; put(1, 1, 0, 0);
    expect_("a_sat_hold", 0, 0, 0, 0, 15, 2);
    expect_("b_r0_forwards", 1, 1, 1, 0, 0, 0); tick();
    idle(1); b_vld = 1; b_rs1 = 4; put(1, 0, 4, 1);
    expect_("b_d2_stall1", 1, 0, 0, 1, 1, 0); tick();
    idle(1);
    expect_("b_d2_stall2_ignores", 1, 0, 0, 1, 1, 1); tick();
    idle(1); b_vld = 1; b_rs1 = 4; put(1, 4, 4, 1);
    expect_("b_load_from_s2", 1, 6, 0, 0, 1, 2); tick();
    idle(1); b_vld = 1; b_rs1 = 4; put(1, 2, 4, 1);
    expect_("b_d1_stall", 1, 0, 0, 1, 2, 2); tick();
    idle(1); b_vld = 1; b_rs1 = 4; put(1, 4, 4, 1);
    expect_("b_d1_release", 1, 6, 0, 0, 2, 3); tick();
    idle(1); b_vld = 1; b_rs1 = 4; put(1, 2, 4, 1); b_rs2 = 8; put(1, 0, 8, 1);
    expect_("b_both_min_stage1", 1, 0, 0, 1, 3, 3); tick();
    idle(1);
    expect_("b_both_min_stage2", 1, 0, 0, 1, 3, 4); tick();
    idle(1);
    expect_("b_both_min_done", 1, 0, 0, 0, 3, 5); tick();
    idle(1); b_vld = 1; b_rs1 = 4; put(1, 0, 4, 1);
    expect_("b_flush_pre", 1, 0, 0, 1, 3, 5); tick();
    b_flush = 1;
    expect_("b_flush_in_stall", 1, 2, 0, 0, 3, 6); tick();
    idle(1);
    expect_("b_after_flush_run", 1, 0, 0, 0, 4, 6); tick();
    idle(1); b_vld = 1; b_rs1 = 4; put(1, 0, 4, 1);
    expect_("b_rst_pre", 1, 0, 0, 1, 4, 6); tick();
    #2 rst_n = 0;
    expect_("b_rst_mid_stall", 1, 0, 0, 0, 0, 0);
    expect_("a_rst_counters", 0, 0, 0, 0, 0, 0); tick();
    rst_n = 1;
    expect_("b_post_rst_hazard", 1, 0, 0, 1, 0, 0); tick();
    idle(1);
    expect_("b_post_rst_stall2", 1, 0, 0, 1, 0, 1); tick();
    expect_("b_post_rst_done", 1, 0, 0, 0, 0, 2); tick();

    for (int i = 0; i < 5 && q.size() > 0; i++) tick();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the multi-issue pipeline.
- Resolves rs_1/rs_2 of the instruction entering EX against every write lane of NUM_STAGES downstream stages. Stage 0 is EX/MEM, stage 1 is MEM/WB, stage 2 is the register-write latch.
- Inserts stall cycles when the best match is a load whose data is not yet forwardable.
- Keeps saturating forward and stall counters.
- Sits between decode/EX pipeline registers and the EX operand muxes.

Parameters:
AW, 5, register address width
ISSUE_W, 2, write lanes per stage
NUM_STAGES, 3, forwarding source stages
LOAD_READY_STAGE, 1, first stage index from which load data may be forwarded (1..NUM_STAGES-1)
ZERO_REG, 1, when 1, source address 0 never forwards
CNT_W, 16, performance counter width
SEL_W, 3, select width; must satisfy 2^SEL_W > NUM_STAGES*ISSUE_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  instruction in decode/EX boundary is valid
flush  in  1  pipeline flush; aborts any stall
rs_1  in  AW  source register A
rs_2  in  AW  source register B
stg_rd  in  NUM_STAGES*ISSUE_W*AW  destination addresses; entry e=stage*ISSUE_W+lane at [e*AW +: AW]
stg_rgw  in  NUM_STAGES*ISSUE_W  register-write enable per entry
stg_ld  in  NUM_STAGES*ISSUE_W  entry is a load
fa  out  SEL_W  operand A select
fb  out  SEL_W  operand B select
stall  out  1  hold PC and IF/ID, inject bubble into EX
fwd_cnt  out  CNT_W  forwarded-instruction count
stall_cnt  out  CNT_W  stall-cycle count

Behaviour:
- Reset (async, rst_n=0): state=RUN, cnt=0, fwd_cnt=0, stall_cnt=0. stall=0, fa=0, fb=0 are forced while rst_n=0.
- Match per source: entry hits if stg_rgw[e] and stg_rd[e]==rs. If ZERO_REG=1 and rs==0, there is no hit.
- Priority: lowest stage first. Within a stage, the highest lane first.
- Select code for winning entry (s, l) = 1 + s*ISSUE_W + (ISSUE_W-1-l). No hit gives 0. With defaults: s0l1=1, s0l0=2, s1l1=3, s1l0=4, s2l1=5, s2l0=6.
- Hazard:
  - Condition: id_valid=1, state=RUN, flush=0, and the winning entry for either source has stg_ld=1 with s<LOAD_READY_STAGE.
  - d = LOAD_READY_STAGE - s, using the smaller s over both sources.
  - Only the winning entry is checked. An older non-load match does not mask a younger load.
- FSM:
  - RUN: stall = hazard.
    - If hazard and d==1, remain in RUN; the next cycle re-evaluates.
    - If hazard and d>=2, go to STALL with cnt=d-2.
  - STALL: stall=1.
    - If cnt==0, go to RUN; else cnt decrements.
    - Inputs are ignored while in STALL.
  - Total stall cycles per hazard = d.
- flush=1 overrides everything in the same cycle: stall=0, next state RUN, cnt=0. Counters are not cleared.
- fa and fb are forced to 0 whenever stall=1. Otherwise they are combinational from the current inputs, regardless of id_valid.
- fwd_cnt: +1 per cycle with id_valid & ~stall & (fa!=0 | fb!=0). Saturates at all-ones.
- stall_cnt: +1 per cycle with stall=1. Saturates at all-ones.
- rst_n asserted mid-stall returns to RUN immediately; stall drops asynchronously.

Test Plan:
- rs_1=7; lanes s0l1 and s1l0 both write r7 (non-load), id_valid=1 -> fa=1, stall=0, fwd_cnt +1 next edge.
- rs_2=9; s0l0 (rd 9) and s1l1 (rd 9) write r9 -> fb=2. Drop s0l0 rgw -> fb=3. Only s2l0 writes r9 -> fb=6.
- rs_1=0 with s0l1 writing r0 and ZERO_REG=1 -> fa=0. Same stimulus with ZERO_REG=0 -> fa=1.
- Load in s0l0, rd=4, rs_1=4, LOAD_READY_STAGE=1 -> stall=1 for exactly 1 cycle with fa=0. Load then presented in s1l0 -> fa=4, stall=0, stall_cnt=1.
- LOAD_READY_STAGE=2, load hit in s0 -> stall high 2 cycles, state passes through STALL. Assert flush on the second cycle -> stall=0 that cycle, RUN next.
- CNT_W=4; hold a forwarding hit for 20 cycles -> fwd_cnt saturates at 15. Pulse rst_n low mid-stall -> stall=0 and both counters 0 immediately.
